regfile: RTL and testbench

Integer register file and register-read stage of the pipeline. Holds x1–x31, performs a registered (one-cycle) read on two ports and one write port, and tracks pending load destinations so the hazard logic can stall on load-use. It sits directly upstream of the forwarding block. That block receives this block's read data and registered read addresses, and overlays any write this block has not yet made visible.

---
 rtl/regfile.sv | 62 ++++++
 tb/tb_regfile.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// Integer register file x1-x31 with a registered two-port read, one write port,
// and a pending-load scoreboard for load-use stall detection.
module regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [4:0]  reg_raddr1,
    input  logic [4:0]  reg_raddr2,
    output logic [31:0] reg_rdata1,
    output logic [31:0] reg_rdata2,
    output logic [4:0]  reg_raddr1_q,
    output logic [4:0]  reg_raddr2_q,
    input  logic [4:0]  reg_waddr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_write,
    input  logic        pend_set,
    input  logic [4:0]  pend_rd,
    output logic        busy1,
    output logic        busy2
);

    logic [31:0] mem [1:31];
    logic [31:0] pend;
    logic        wr_en;
    logic        set_en;

    assign wr_en  = reg_write && (reg_waddr != '0);
    assign set_en = pend_set && (pend_rd != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 1; i < 32; i++) begin
                mem[i[4:0]] <= '0;
            end
            pend         <= '0;
            reg_rdata1   <= '0;
            reg_rdata2   <= '0;
            reg_raddr1_q <= '0;
            reg_raddr2_q <= '0;
        end else if (!stall) begin
            if (wr_en) begin
                mem[reg_waddr] <= reg_wdata;
            end
            // Reads sample the pre-edge contents; same-edge writes are left to the forwarding stage.
            reg_rdata1   <= (reg_raddr1 == '0) ? '0 : mem[reg_raddr1];
            reg_rdata2   <= (reg_raddr2 == '0) ? '0 : mem[reg_raddr2];
            reg_raddr1_q <= reg_raddr1;
            reg_raddr2_q <= reg_raddr2;
            // Set is applied after clear so a newly issued load supersedes a retiring one.
            if (wr_en) begin
                pend[reg_waddr] <= 1'b0;
            end
            if (set_en) begin
                pend[pend_rd] <= 1'b1;
            end
        end
    end

    assign busy1 = pend[reg_raddr1_q];
    assign busy2 = pend[reg_raddr2_q];

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed vector table, hand-written reset sequences, and
// randomized traffic compared against an array-based reference model.
module tb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [4:0]  reg_raddr1, reg_raddr2;
    logic [31:0] reg_rdata1, reg_rdata2;
    logic [4:0]  reg_raddr1_q, reg_raddr2_q;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        reg_write;
    logic        pend_set;
    logic [4:0]  pend_rd;
    logic        busy1, busy2;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    always #5 clk = ~clk;

    regfile dut (
        .clk(clk), .reset(reset), .stall(stall),
        .reg_raddr1(reg_raddr1), .reg_raddr2(reg_raddr2),
        .reg_rdata1(reg_rdata1), .reg_rdata2(reg_rdata2),
        .reg_raddr1_q(reg_raddr1_q), .reg_raddr2_q(reg_raddr2_q),
        .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_write(reg_write),
        .pend_set(pend_set), .pend_rd(pend_rd),
        .busy1(busy1), .busy2(busy2)
    );

    typedef struct {
        logic        stall;
        logic [4:0]  ra1, ra2;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ps;
        logic [4:0]  prd;
        logic [31:0] r1, r2;
        logic [4:0]  q1, q2;
        logic        b1, b2;
    } vec_t;

    vec_t tbl[15];

    // Reference model: architectural register contents and outstanding-load set.
    logic [31:0] m_reg  [32];
    bit          m_pend [32];
    logic [31:0] m_r1, m_r2;
    logic [4:0]  m_q1, m_q2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic st, input logic [4:0] ra1, input logic [4:0] ra2,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ps, input logic [4:0] prd);
        stall = st; reg_raddr1 = ra1; reg_raddr2 = ra2;
        reg_write = we; reg_waddr = wa; reg_wdata = wd;
        pend_set = ps; pend_rd = prd;
    endtask

    task automatic drive_garbage();
        drive(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
              $urandom, 1'($urandom), 5'($urandom));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " rdata1"}, reg_rdata1, 32'h0);
        chk({tag, " rdata2"}, reg_rdata2, 32'h0);
        chk({tag, " raddr1_q"}, 32'(reg_raddr1_q), 32'h0);
        chk({tag, " raddr2_q"}, 32'(reg_raddr2_q), 32'h0);
        chk({tag, " busy1"}, 32'(busy1), 32'h0);
        chk({tag, " busy2"}, 32'(busy2), 32'h0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_r1 = '0; m_r2 = '0; m_q1 = '0; m_q2 = '0;
    endtask

    // One architectural step: reads see the old contents, then the write lands,
    // then the scoreboard retires the written register and records the new load.
    task automatic model_edge();
        if (!stall) begin
            m_r1 = m_reg[reg_raddr1];
            m_r2 = m_reg[reg_raddr2];
            m_q1 = reg_raddr1;
            m_q2 = reg_raddr2;
            if (reg_write && reg_waddr != 0) begin
                m_reg[reg_waddr]  = reg_wdata;
                m_pend[reg_waddr] = 1'b0;
            end
            if (pend_set && pend_rd != 0) m_pend[pend_rd] = 1'b1;
        end
    endtask

    initial begin
        // Reset asserted from time zero with arbitrary inputs.
        reset = 1'b0;
        drive_garbage();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("por");
        @(negedge clk);
        reset = 1'b1;

        //        st ra1 ra2 we wa  wd            ps prd r1            r2     q1 q2 b1 b2
        tbl[0]  = '{0, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0,  5, 0, 0, 0};
        tbl[1]  = '{0, 5, 0, 0, 0, 32'h0,        0, 0, 32'hDEADBEEF, 32'h0,  5, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 0, 32'h1234,     0, 0, 32'h0,        32'h0,  0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0,  0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 3, 32'hA5A5A5A5, 0, 0, 32'h0,        32'h0,  0, 0, 0, 0};
        tbl[5]  = '{0, 3, 0, 0, 0, 32'h0,        0, 0, 32'hA5A5A5A5, 32'h0,  3, 0, 0, 0};
        tbl[6]  = '{1, 4, 0, 1, 3, 32'h1,        0, 0, 32'hA5A5A5A5, 32'h0,  3, 0, 0, 0};
        tbl[7]  = '{0, 3, 0, 0, 0, 32'h0,        0, 0, 32'hA5A5A5A5, 32'h0,  3, 0, 0, 0};
        tbl[8]  = '{0, 0, 7, 0, 0, 32'h0,        1, 7, 32'h0,        32'h0,  0, 7, 0, 1};
        tbl[9]  = '{0, 0, 7, 1, 7, 32'h77,       0, 0, 32'h0,        32'h0,  0, 7, 0, 0};
        tbl[10] = '{0, 0, 7, 0, 0, 32'h0,        0, 0, 32'h0,        32'h77, 0, 7, 0, 0};
        tbl[11] = '{0, 0, 7, 1, 7, 32'h88,       1, 7, 32'h0,        32'h77, 0, 7, 0, 1};
        tbl[12] = '{0, 3, 7, 0, 0, 32'h0,        0, 0, 32'hA5A5A5A5, 32'h88, 3, 7, 0, 1};
        tbl[13] = '{1, 0, 0, 0, 0, 32'h0,        1, 3, 32'hA5A5A5A5, 32'h88, 3, 7, 0, 1};
        tbl[14] = '{0, 3, 7, 0, 0, 32'h0,        0, 0, 32'hA5A5A5A5, 32'h88, 3, 7, 0, 1};

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].stall, tbl[i].ra1, tbl[i].ra2, tbl[i].we, tbl[i].wa, tbl[i].wd,
                  tbl[i].ps, tbl[i].prd);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d rdata1", i), reg_rdata1, tbl[i].r1);
            chk($sformatf("row%0d rdata2", i), reg_rdata2, tbl[i].r2);
            chk($sformatf("row%0d raddr1_q", i), 32'(reg_raddr1_q), 32'(tbl[i].q1));
            chk($sformatf("row%0d raddr2_q", i), 32'(reg_raddr2_q), 32'(tbl[i].q2));
            chk($sformatf("row%0d busy1", i), 32'(busy1), 32'(tbl[i].b1));
            chk($sformatf("row%0d busy2", i), 32'(busy2), 32'(tbl[i].b2));
        end

        // Reset mid-operation: x9 written with a pending load, then async reset mid-cycle.
        drive(0, 0, 0, 1, 9, 32'h99999999, 1, 9);
        @(posedge clk); #1;
        drive(0, 9, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("mid x9 rdata1", reg_rdata1, 32'h99999999);
        chk("mid x9 busy1", 32'(busy1), 32'h1);
        #2;
        drive_garbage();
        reset = 1'b0;
        #1;
        check_all_zero("async");
        @(posedge clk); #1;
        check_all_zero("async held");
        @(negedge clk);
        reset = 1'b1;
        drive(0, 9, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("post x9 rdata1", reg_rdata1, 32'h0);
        chk("post x9 raddr1_q", 32'(reg_raddr1_q), 32'h9);
        chk("post x9 busy1", 32'(busy1), 32'h0);

        // Every register reads back as zero after reset.
        for (int i = 1; i < 32; i++) begin
            drive(0, 5'(i), 5'(32 - i), 0, 0, 0, 0, 0);
            @(posedge clk); #1;
            chk($sformatf("zero x%0d p1", i), reg_rdata1, 32'h0);
            chk($sformatf("zero x%0d p2", 32 - i), reg_rdata2, 32'h0);
        end

        // Randomized traffic against the reference model.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 4) == 0), 5'($urandom_range(0, 7)), 5'($urandom),
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("rnd%0d rdata1", n), reg_rdata1, m_r1);
            chk($sformatf("rnd%0d rdata2", n), reg_rdata2, m_r2);
            chk($sformatf("rnd%0d raddr1_q", n), 32'(reg_raddr1_q), 32'(m_q1));
            chk($sformatf("rnd%0d raddr2_q", n), 32'(reg_raddr2_q), 32'(m_q2));
            chk($sformatf("rnd%0d busy1", n), 32'(busy1), 32'(m_pend[m_q1]));
            chk($sformatf("rnd%0d busy2", n), 32'(busy2), 32'(m_pend[m_q2]));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
